// File: rtl/mmu_responder_if.sv
// MMU request/response bus between the core's control FSM (master) and the
// memory-side responder (slave).
interface mmu_responder_if;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [1:0]  req_size;
  logic [35:0] req_addr;
  logic [63:0] req_wdata;
  logic        mmu_ready;
  logic [63:0] mmu_result_data;
  logic [15:0] mmu_result_code;

  modport master (
    output req_valid, req_op, req_size, req_addr, req_wdata,
    input  mmu_ready, mmu_result_data, mmu_result_code
  );

  modport slave (
    input  req_valid, req_op, req_size, req_addr, req_wdata,
    output mmu_ready, mmu_result_data, mmu_result_code
  );
endinterface

// File: rtl/mmu_responder.sv
// Memory-side responder: internal RAM plus external synchronous ROM window, with
// alignment, mapping and write-protection checks on each accepted request.
module mmu_responder #(
  parameter logic [35:0] RAM_BASE       = 36'h0_0000_0000,
  parameter logic [35:0] ROM_BASE       = 36'h4_0000_0000,
  parameter int unsigned RAM_WORDS_LOG2 = 10,
  parameter int unsigned ROM_WORDS_LOG2 = 12,
  parameter int unsigned WAIT_CYCLES    = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clock_enable,
  mmu_responder_if.slave            bus,
  output logic [ROM_WORDS_LOG2-1:0] rom_rd_addr,
  input  logic [63:0]               rom_rd_data
);

  localparam int unsigned CntW = $clog2(WAIT_CYCLES + 1);
  localparam logic [36:0] RamBytes = 37'd8 << RAM_WORDS_LOG2;
  localparam logic [36:0] RomBytes = 37'd8 << ROM_WORDS_LOG2;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StWait    = 2'd1;
  localparam logic [1:0] StRespErr = 2'd2;

  localparam logic [1:0] OpFetch = 2'b00;
  localparam logic [1:0] OpLoad  = 2'b01;
  localparam logic [1:0] OpStore = 2'b10;
  localparam logic [1:0] OpRsvd  = 2'b11;

  logic [63:0] ram [2**RAM_WORDS_LOG2];

  logic [1:0]                state_q;
  logic [CntW-1:0]           cnt_q;
  logic [1:0]                op_q;
  logic [1:0]                size_q;
  logic [2:0]                off_q;
  logic [63:0]               wdata_q;
  logic                      in_rom_q;
  logic [RAM_WORDS_LOG2-1:0] ram_idx_q;
  logic [15:0]               err_q;
  logic                      ready_q;
  logic [63:0]               data_q;
  logic [15:0]               code_q;

  assign bus.mmu_ready       = ready_q;
  assign bus.mmu_result_data = data_q;
  assign bus.mmu_result_code = code_q;

  // Region test via 37-bit offset: negative offsets set bit 36, so no upper-bound overflow.
  logic [36:0] ram_off, rom_off;
  logic        in_ram, in_rom, misaligned;
  logic [15:0] err_code;

  always_comb begin
    ram_off = {1'b0, bus.req_addr} - {1'b0, RAM_BASE};
    rom_off = {1'b0, bus.req_addr} - {1'b0, ROM_BASE};
    in_ram  = !ram_off[36] && (ram_off < RamBytes);
    in_rom  = !rom_off[36] && (rom_off < RomBytes);
    if (bus.req_op == OpFetch) begin
      misaligned = (bus.req_size != 2'b10) || (bus.req_addr[1:0] != 2'b00);
    end else begin
      case (bus.req_size)
        2'b00:   misaligned = 1'b0;
        2'b01:   misaligned = bus.req_addr[0];
        2'b10:   misaligned = bus.req_addr[1:0] != 2'b00;
        default: misaligned = bus.req_addr[2:0] != 3'b000;
      endcase
    end
    err_code = 16'h0000;
    if (bus.req_op == OpRsvd)                       err_code = 16'h0004;
    else if (!in_ram && !in_rom)                    err_code = 16'h0002;
    else if (misaligned)                            err_code = 16'h0001;
    else if (bus.req_op == OpStore && !in_ram)      err_code = 16'h0003;
  end

  logic        done;
  logic [63:0] word, shifted, load_data, fetch_data, wsh, merged, result;
  logic [7:0]  lane_mask, be;

  always_comb begin
    done    = (state_q == StWait) && (cnt_q == CntW'(1));
    word    = in_rom_q ? rom_rd_data : ram[ram_idx_q];
    shifted = word >> {off_q, 3'b000};
    case (size_q)
      2'b00:   begin load_data = {56'h0, shifted[7:0]};  lane_mask = 8'h01; end
      2'b01:   begin load_data = {48'h0, shifted[15:0]}; lane_mask = 8'h03; end
      2'b10:   begin load_data = {32'h0, shifted[31:0]}; lane_mask = 8'h0f; end
      default: begin load_data = shifted;                lane_mask = 8'hff; end
    endcase
    fetch_data = {(off_q[2] ? word[63:32] : word[31:0]), 32'h0};
    be     = lane_mask << off_q;
    wsh    = wdata_q << {off_q, 3'b000};
    merged = word;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) merged[8*i +: 8] = wsh[8*i +: 8];
    end
    case (op_q)
      OpFetch: result = fetch_data;
      OpLoad:  result = load_data;
      default: result = 64'h0;
    endcase
  end

  // An async reset forces state_q to idle before the next edge, so no pending store lands.
  always_ff @(posedge clock) begin
    if (clock_enable && done && op_q == OpStore && !in_rom_q) begin
      ram[ram_idx_q] <= merged;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= OpFetch;
      size_q      <= 2'b00;
      off_q       <= 3'b000;
      wdata_q     <= 64'h0;
      in_rom_q    <= 1'b0;
      ram_idx_q   <= '0;
      err_q       <= 16'h0;
      ready_q     <= 1'b1;
      data_q      <= 64'h0;
      code_q      <= 16'h0;
      rom_rd_addr <= '0;
    end else if (clock_enable) begin
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            op_q      <= bus.req_op;
            size_q    <= bus.req_size;
            off_q     <= bus.req_addr[2:0];
            wdata_q   <= bus.req_wdata;
            in_rom_q  <= !in_ram && in_rom;
            ram_idx_q <= ram_off[RAM_WORDS_LOG2+2:3];
            ready_q   <= 1'b0;
            if (err_code != 16'h0) begin
              err_q   <= err_code;
              state_q <= StRespErr;
            end else begin
              cnt_q   <= CntW'(WAIT_CYCLES);
              state_q <= StWait;
              if (!in_ram && in_rom) rom_rd_addr <= rom_off[ROM_WORDS_LOG2+2:3];
            end
          end
        end
        StRespErr: begin
          code_q  <= err_q;
          data_q  <= 64'h0;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        StWait: begin
          cnt_q <= cnt_q - CntW'(1);
          if (done) begin
            data_q  <= result;
            code_q  <= 16'h0;
            ready_q <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/mmu_responder.md
Name: mmu_responder

Overview:
Memory-side responder for the core's MMU request interface. It answers the control FSM's instruction fetches, loads and stores with mmu_ready, mmu_result_data and mmu_result_code. It contains an internal RAM, maps a read-only ROM region onto an external synchronous ROM port, and checks alignment, mapping and write protection.
It is the server end of the interface the execute/state-register FSM consumes.

Parameters:
RAM_BASE, 36'h0_0000_0000, byte base address of the RAM region
ROM_BASE, 36'h4_0000_0000, byte base address of the ROM region (reset PC)
RAM_WORDS_LOG2, 10, RAM depth in 64-bit words
ROM_WORDS_LOG2, 12, ROM depth in 64-bit words
WAIT_CYCLES, 2, extra busy cycles per valid access; must be >= 1

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
clock_enable  in  1  when low, all state frozen
req_valid  in  1  request strobe
req_op  in  2  00 fetch, 01 load, 10 store, 11 reserved
req_size  in  2  00 byte, 01 half, 10 word, 11 dword
req_addr  in  36  byte address
req_wdata  in  64  store data, right-justified
mmu_ready  out  1  idle / result valid
mmu_result_data  out  64  fetch: instruction in [63:32], [31:0]=0; load: zero-extended right-justified; store or error: 0
mmu_result_code  out  16  0000 ok, 0001 misaligned, 0002 unmapped, 0003 ROM write, 0004 illegal op
rom_rd_addr  out  ROM_WORDS_LOG2  ROM word index, registered
rom_rd_data  in  64  ROM word, valid one cycle after rom_rd_addr changes

Behaviour:
- Reset values: mmu_ready=1, mmu_result_data=0, mmu_result_code=0, rom_rd_addr=0, state=IDLE, wait counter=0.
- Reset mid-access aborts the access. A pending store is not written.
- All state advances only on edges with clock_enable=1.
- States: IDLE, WAIT, RESP_ERR.
- Accept occurs on an edge where state=IDLE, req_valid=1 and clock_enable=1. The request is latched and mmu_ready goes to 0.
- req_valid is ignored while mmu_ready=0.
- Checks at accept, in priority order:
  - req_op=11 gives code 0004.
  - Address outside both regions gives 0002.
  - Misaligned gives 0001. Misaligned means the address is not a multiple of the access size; a fetch is misaligned if req_size!=10 or addr[1:0]!=0.
  - Store to ROM gives 0003.
  - Any failed check goes to RESP_ERR.
- RESP_ERR: on the next edge, load the code, set data=0, mmu_ready=1, go to IDLE. Error latency is 1 cycle.
- Valid access: go to WAIT, counter=WAIT_CYCLES, and drive rom_rd_addr from the word index (addr-ROM_BASE)>>3 if in ROM.
- WAIT: the counter decrements each edge. On the edge where the counter is 1:
  - Word source is the RAM word (read of the latched index) or rom_rd_data.
  - Lanes are little-endian; byte offset is addr[2:0].
  - Load: extract size bytes from the offset and zero-extend.
  - Fetch: bits [32*addr[2]+31 : 32*addr[2]] go to result [63:32].
  - Store: byte-merge req_wdata lanes into the RAM word and write it the same edge; result data=0.
  - Set code=0000 and mmu_ready=1, return to IDLE.
  - Valid latency: WAIT_CYCLES cycles from accept to mmu_ready=1.
- Results hold stable while mmu_ready=1 until the next accept. Outputs are not changed at accept, only at completion.
- A new request may be accepted on the same edge the previous one completes? No: accept requires state=IDLE at the edge, so back-to-back accepts are spaced by at least one ready-high cycle.
- Address region test uses unsigned 36-bit compare: base <= addr < base + 8*2^WORDS_LOG2. The upper bound is computed in 37 bits so a region ending at 2^36 wraps without overflow.
- The RAM is uninitialised in hardware. The bench initialises it via stores.

Test Plan:
- Reset, then check mmu_ready=1, data=0, code=0. Fetch at 36'h4_0000_0004 with rom_rd_data=64'hAABBCCDD_00000013 -> ready low 2 cycles, then data=64'hAABBCCDD_00000000, code=0.
- Store dword 64'h1122334455667788 at 0x10, then load byte at 0x13 -> data=64'h55, code=0. Load half at 0x16 -> 64'h1122.
- Store byte 8'hEE at 0x11 over that word, then load dword 0x10 -> 64'h112233445566EE88.
- Load word at 0x2 -> misaligned, code=0001 after 1 cycle. Load at 36'h2_0000_0000 -> 0002. Store to ROM_BASE -> 0003, RAM unchanged. op=11 -> 0004.
- Assert reset during WAIT of a store to 0x20 -> ready=1 immediately, later load 0x20 returns the old value.
- Hold clock_enable=0 for 5 cycles mid-WAIT -> ready stays 0; completion is delayed by exactly 5 cycles. Toggle req_valid while busy -> no extra access.
